// File: rtl/ysyx_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the downstream
// memory port. The arbiter uses the slave view; requesters and memory use master.
interface ysyx_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IFU side
  logic [ADDR_W-1:0]   ifu_araddr_i;
  logic                ifu_arvalid_i;
  logic [DATA_W-1:0]   ifu_rdata_o;
  logic                ifu_rvalid_o;
  // LSU side
  logic [ADDR_W-1:0]   lsu_addr_i;
  logic                lsu_arvalid_i;
  logic                lsu_awvalid_i;
  logic [DATA_W-1:0]   lsu_wdata_i;
  logic [DATA_W/8-1:0] lsu_wstrb_i;
  logic [DATA_W-1:0]   lsu_rdata_o;
  logic                lsu_rvalid_o;
  logic                lsu_bvalid_o;
  // Downstream memory side
  logic [ADDR_W-1:0]   mem_addr_o;
  logic                mem_req_o;
  logic                mem_we_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W/8-1:0] mem_wstrb_o;
  logic                mem_ready_i;
  logic                mem_resp_i;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic                bus_err_o;

  modport slave (
    input  ifu_araddr_i, ifu_arvalid_i,
    output ifu_rdata_o, ifu_rvalid_o,
    input  lsu_addr_i, lsu_arvalid_i, lsu_awvalid_i, lsu_wdata_i, lsu_wstrb_i,
    output lsu_rdata_o, lsu_rvalid_o, lsu_bvalid_o,
    output mem_addr_o, mem_req_o, mem_we_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i, mem_resp_i, mem_rdata_i,
    output bus_err_o
  );

  modport master (
    output ifu_araddr_i, ifu_arvalid_i,
    input  ifu_rdata_o, ifu_rvalid_o,
    output lsu_addr_i, lsu_arvalid_i, lsu_awvalid_i, lsu_wdata_i, lsu_wstrb_i,
    input  lsu_rdata_o, lsu_rvalid_o, lsu_bvalid_o,
    input  mem_addr_o, mem_req_o, mem_we_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_i, mem_resp_i, mem_rdata_i,
    input  bus_err_o
  );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the IFU (reads only) and
// the LSU (reads and writes). Request fields are registered at grant; the
// response is routed to the owner only, and hung transfers end in an error.
module ysyx_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  ysyx_mem_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic ifu_req, lsu_req, complete, timeout_hit, resp_en;

  // State and latched request fields; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_IFU;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant selection, handshake progress, completion and timeout detection.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    ifu_req  = bus.ifu_arvalid_i;
    lsu_req  = bus.lsu_arvalid_i | bus.lsu_awvalid_i;

    case (state_q)
      S_IDLE: begin
        if (ifu_req || lsu_req) begin
          // LSU wins when alone, or on a tie when the IFU was served last.
          if (lsu_req && (!ifu_req || last_q == OWN_IFU)) begin
            owner_d = OWN_LSU;
            addr_d  = bus.lsu_addr_i;
            we_d    = bus.lsu_awvalid_i;
            wdata_d = bus.lsu_awvalid_i ? bus.lsu_wdata_i : '0;
            wstrb_d = bus.lsu_awvalid_i ? bus.lsu_wstrb_i : '0;
          end else begin
            owner_d = OWN_IFU;
            addr_d  = bus.ifu_araddr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        complete = bus.mem_ready_i & bus.mem_resp_i;
        if (bus.mem_ready_i && !bus.mem_resp_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        complete = bus.mem_resp_i;
      end
      default: state_d = S_IDLE;
    endcase

    // A genuine response in the last allowed cycle beats the timeout.
    timeout_hit = (state_q != S_IDLE) && !complete && (cnt_q == CNT_LAST);
    if (state_q != S_IDLE) cnt_d = cnt_q + CNT_W'(1);

    if (complete || timeout_hit) begin
      state_d = S_IDLE;
      last_d  = owner_q;
    end

    resp_en = (complete | timeout_hit) & ~rst;
  end

  assign bus.mem_req_o    = (state_q == S_REQ);
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_wstrb_o  = wstrb_q;

  assign bus.ifu_rvalid_o = resp_en && (owner_q == OWN_IFU);
  assign bus.lsu_rvalid_o = resp_en && (owner_q == OWN_LSU) && !we_q;
  assign bus.lsu_bvalid_o = resp_en && (owner_q == OWN_LSU) && we_q;
  // Read data only passes on a real completion; a timeout returns zero.
  assign bus.ifu_rdata_o  = (resp_en && complete && owner_q == OWN_IFU) ? bus.mem_rdata_i : '0;
  assign bus.lsu_rdata_o  = (resp_en && complete && owner_q == OWN_LSU && !we_q) ? bus.mem_rdata_i : '0;
  assign bus.bus_err_o    = resp_en & timeout_hit;
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter with a response scoreboard.
module tb_ysyx_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ysyx_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_lsu;
    bit          is_wr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_lsu, input bit is_wr, input logic [31:0] rd, input bit err);
    exp_t e;
    e.is_lsu = is_lsu;
    e.is_wr  = is_wr;
    e.rdata  = rd;
    e.err    = err;
    sb.push_back(e);
  endtask

  function automatic logic any_valid();
    return bus.ifu_rvalid_o | bus.lsu_rvalid_o | bus.lsu_bvalid_o;
  endfunction

  // Monitor: pop and compare whenever a response pulse is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (any_valid()) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(any_valid()), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          $display("resp: ifu_rv=%0b lsu_rv=%0b lsu_bv=%0b ifu_rd=%08h lsu_rd=%08h err=%0b",
                   bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.lsu_bvalid_o,
                   bus.ifu_rdata_o, bus.lsu_rdata_o, bus.bus_err_o);
          chk("resp_ifu_rvalid", 32'(bus.ifu_rvalid_o), 32'(!mon_e.is_lsu));
          chk("resp_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(mon_e.is_lsu && !mon_e.is_wr));
          chk("resp_lsu_bvalid", 32'(bus.lsu_bvalid_o), 32'(mon_e.is_lsu && mon_e.is_wr));
          chk("resp_rdata", mon_e.is_lsu ? bus.lsu_rdata_o : bus.ifu_rdata_o, mon_e.rdata);
          chk("resp_bus_err", 32'(bus.bus_err_o), 32'(mon_e.err));
        end
      end else begin
        chk("idle_bus_err", 32'(bus.bus_err_o), 32'd0);
      end
      if (!bus.ifu_rvalid_o) chk("ifu_rdata_zero", bus.ifu_rdata_o, 32'd0);
      if (!bus.lsu_rvalid_o) chk("lsu_rdata_zero", bus.lsu_rdata_o, 32'd0);
    end
  end

  // Plays the memory: waits for a request, checks the presented fields each
  // REQ cycle, accepts after rdy cycles, responds after rsp WAIT cycles
  // (rsp = 0 means response together with acceptance).
  task automatic serve(input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input int rdy, input int rsp, input logic [31:0] rd);
    int n;
    n = 0;
    while (!bus.mem_req_o) begin
      if (n == 20) begin
        chk({tag, "_req_timeout"}, 32'd0, 32'd1);
        return;
      end
      tick();
      n++;
    end
    for (int k = 0; k <= rdy; k++) begin
      chk({tag, "_mem_req"}, 32'(bus.mem_req_o), 32'd1);
      chk({tag, "_mem_addr"}, bus.mem_addr_o, a);
      chk({tag, "_mem_we"}, 32'(bus.mem_we_o), 32'(w));
      chk({tag, "_mem_wdata"}, bus.mem_wdata_o, wd);
      chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb_o), 32'(ws));
      if (k < rdy) chk({tag, "_no_early_resp"}, 32'(any_valid()), 32'd0);
      if (k == rdy) begin
        bus.mem_ready_i = 1'b1;
        if (rsp == 0) begin
          bus.mem_resp_i  = 1'b1;
          bus.mem_rdata_i = rd;
        end
      end
      tick();
      bus.mem_ready_i = 1'b0;
      bus.mem_resp_i  = 1'b0;
      bus.mem_rdata_i = 32'd0;
    end
    if (rsp > 0) begin
      for (int k = 1; k <= rsp; k++) begin
        chk({tag, "_wait_req_low"}, 32'(bus.mem_req_o), 32'd0);
        chk({tag, "_wait_no_resp"}, 32'(any_valid()), 32'd0);
        if (k == rsp) begin
          bus.mem_resp_i  = 1'b1;
          bus.mem_rdata_i = rd;
        end
        tick();
      end
      bus.mem_resp_i  = 1'b0;
      bus.mem_rdata_i = 32'd0;
    end
  endtask

  initial begin
    bus.ifu_araddr_i  = '0;
    bus.ifu_arvalid_i = 1'b0;
    bus.lsu_addr_i    = '0;
    bus.lsu_arvalid_i = 1'b0;
    bus.lsu_awvalid_i = 1'b0;
    bus.lsu_wdata_i   = '0;
    bus.lsu_wstrb_i   = '0;
    bus.mem_ready_i   = 1'b0;
    bus.mem_resp_i    = 1'b0;
    bus.mem_rdata_i   = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
    chk("rst_valids", 32'(any_valid()), 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err_o), 32'd0);

    // Both requesting right after reset: LSU, IFU, LSU. LSU read zeroes wdata/wstrb.
    bus.ifu_araddr_i  = 32'h8000_0100;
    bus.ifu_arvalid_i = 1'b1;
    bus.lsu_addr_i    = 32'h8000_2000;
    bus.lsu_arvalid_i = 1'b1;
    bus.lsu_wdata_i   = 32'hFFFF_FFFF;
    bus.lsu_wstrb_i   = 4'hF;
    push(1, 0, 32'h0000_0011, 0);
    serve("rr1_lsu", 32'h8000_2000, 1'b0, 32'd0, 4'h0, 0, 1, 32'h0000_0011);
    push(0, 0, 32'h0000_0022, 0);
    serve("rr2_ifu", 32'h8000_0100, 1'b0, 32'd0, 4'h0, 0, 1, 32'h0000_0022);
    push(1, 0, 32'h0000_0033, 0);
    serve("rr3_lsu", 32'h8000_2000, 1'b0, 32'd0, 4'h0, 1, 0, 32'h0000_0033);
    bus.ifu_arvalid_i = 1'b0;
    bus.lsu_arvalid_i = 1'b0;
    tick();

    // IFU only
    bus.ifu_araddr_i  = 32'h8000_0000;
    bus.ifu_arvalid_i = 1'b1;
    push(0, 0, 32'h0000_0413, 0);
    serve("ifu_only", 32'h8000_0000, 1'b0, 32'd0, 4'h0, 0, 2, 32'h0000_0413);
    bus.ifu_arvalid_i = 1'b0;
    tick();

    // LSU write, fields held until accepted
    bus.lsu_addr_i    = 32'h8000_1000;
    bus.lsu_awvalid_i = 1'b1;
    bus.lsu_wdata_i   = 32'hDEAD_BEEF;
    bus.lsu_wstrb_i   = 4'hF;
    push(1, 1, 32'd0, 0);
    serve("lsu_wr", 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'hCAFE_0000);
    bus.lsu_awvalid_i = 1'b0;
    tick();

    // LSU read and write both high: write
    bus.lsu_addr_i    = 32'h8000_1004;
    bus.lsu_arvalid_i = 1'b1;
    bus.lsu_awvalid_i = 1'b1;
    bus.lsu_wdata_i   = 32'h1234_5678;
    bus.lsu_wstrb_i   = 4'h3;
    push(1, 1, 32'd0, 0);
    serve("lsu_rw", 32'h8000_1004, 1'b1, 32'h1234_5678, 4'h3, 0, 1, 32'h0BAD_0BAD);
    bus.lsu_arvalid_i = 1'b0;
    bus.lsu_awvalid_i = 1'b0;
    tick();

    // Ready delayed 5 cycles: six stable REQ cycles
    bus.ifu_araddr_i  = 32'h8000_0040;
    bus.ifu_arvalid_i = 1'b1;
    push(0, 0, 32'hA5A5_0001, 0);
    serve("rdy_dly", 32'h8000_0040, 1'b0, 32'd0, 4'h0, 5, 0, 32'hA5A5_0001);
    bus.ifu_arvalid_i = 1'b0;
    tick();

    // Timeout: no memory activity, error pulse in the 8th REQ cycle
    bus.ifu_araddr_i  = 32'h8000_0080;
    bus.ifu_arvalid_i = 1'b1;
    push(0, 0, 32'd0, 1);
    tick();
    chk("to_mem_req", 32'(bus.mem_req_o), 32'd1);
    repeat (7) begin
      chk("to_no_early_resp", 32'(any_valid()), 32'd0);
      tick();
    end
    chk("to_ifu_rvalid", 32'(bus.ifu_rvalid_o), 32'd1);
    chk("to_bus_err", 32'(bus.bus_err_o), 32'd1);
    chk("to_ifu_rdata", bus.ifu_rdata_o, 32'd0);
    bus.ifu_arvalid_i = 1'b0;
    tick();
    chk("to_idle_req", 32'(bus.mem_req_o), 32'd0);
    bus.lsu_addr_i    = 32'h8000_3000;
    bus.lsu_arvalid_i = 1'b1;
    push(1, 0, 32'h0000_0066, 0);
    serve("after_to", 32'h8000_3000, 1'b0, 32'd0, 4'h0, 0, 0, 32'h0000_0066);
    bus.lsu_arvalid_i = 1'b0;
    tick();

    // Response in the last allowed cycle wins over the timeout
    bus.ifu_araddr_i  = 32'h8000_00C0;
    bus.ifu_arvalid_i = 1'b1;
    push(0, 0, 32'h0000_0055, 0);
    serve("to_race", 32'h8000_00C0, 1'b0, 32'd0, 4'h0, 7, 0, 32'h0000_0055);
    bus.ifu_arvalid_i = 1'b0;
    tick();

    // Reset while in WAIT, late response ignored, then a normal grant
    bus.ifu_araddr_i  = 32'h8000_0200;
    bus.ifu_arvalid_i = 1'b1;
    tick();
    chk("rw_req", 32'(bus.mem_req_o), 32'd1);
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    chk("rw_wait_req_low", 32'(bus.mem_req_o), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.ifu_arvalid_i = 1'b0;
    bus.mem_resp_i    = 1'b1;
    bus.mem_rdata_i   = 32'h0000_0077;
    chk("rw_late_resp_ifu", 32'(bus.ifu_rvalid_o), 32'd0);
    chk("rw_late_resp_lsu", 32'(bus.lsu_rvalid_o | bus.lsu_bvalid_o), 32'd0);
    tick();
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = 32'd0;
    chk("rw_idle_req", 32'(bus.mem_req_o), 32'd0);
    bus.ifu_araddr_i  = 32'h8000_0204;
    bus.ifu_arvalid_i = 1'b1;
    push(0, 0, 32'h0000_0088, 0);
    serve("rw_next", 32'h8000_0204, 1'b0, 32'd0, 4'h0, 0, 1, 32'h0000_0088);
    bus.ifu_arvalid_i = 1'b0;
    repeat (3) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_mem_arbiter.md
Name: ysyx_mem_arbiter

Overview:
Shares the single core memory bus between the instruction fetch unit (read-only) and the load/store unit (read/write).
It grants one requester at a time and drives the downstream bus with registered request fields. It routes the response pulse back to the owner only, and times out hung transactions with an error response.
It sits between the IFU/LSU and the memory/crossbar port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 1024, maximum cycles in REQ+WAIT before a forced error response (minimum 4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_araddr_i  in  ADDR_W  IFU fetch address
ifu_arvalid_i  in  1  IFU read request
ifu_rdata_o  out  DATA_W  IFU read data; valid only with ifu_rvalid_o
ifu_rvalid_o  out  1  one-cycle IFU response
lsu_addr_i  in  ADDR_W  LSU address
lsu_arvalid_i  in  1  LSU read request
lsu_awvalid_i  in  1  LSU write request
lsu_wdata_i  in  DATA_W  LSU write data
lsu_wstrb_i  in  DATA_W/8  LSU byte strobes
lsu_rdata_o  out  DATA_W  LSU read data
lsu_rvalid_o  out  1  one-cycle LSU read response
lsu_bvalid_o  out  1  one-cycle LSU write response
mem_addr_o  out  ADDR_W  downstream address
mem_req_o  out  1  downstream request valid
mem_we_o  out  1  1 = write
mem_wdata_o  out  DATA_W  downstream write data
mem_wstrb_o  out  DATA_W/8  downstream strobes
mem_ready_i  in  1  downstream accepted the request
mem_resp_i  in  1  downstream response valid (read data or write ack)
mem_rdata_i  in  DATA_W  downstream read data
bus_err_o  out  1  high together with the response pulse when the response is a timeout

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state IDLE, last_owner = IFU, timeout counter 0.
  - All mem_* outputs 0. All rvalid/bvalid and bus_err_o 0. rdata outputs 0.
- Reset mid-transaction: abandon the transaction; no response is issued. Any later mem_resp_i is ignored while in IDLE.
- State IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one that is not last_owner (round-robin). Directly after reset, the LSU wins.
  - On grant, latch owner, address, we, wdata and wstrb (wdata and wstrb are zeroed for reads), clear the counter, and go to REQ.
  - If lsu_arvalid_i and lsu_awvalid_i are both high, perform a write.
- State REQ:
  - mem_req_o = 1 with the latched fields; they stay stable until mem_ready_i.
  - mem_ready_i & mem_resp_i → complete.
  - mem_ready_i alone → WAIT.
  - Otherwise hold.
- State WAIT:
  - mem_req_o = 0.
  - mem_resp_i → complete. Otherwise hold.
- Complete (combinational in the completing cycle):
  - Pulse the owner's rvalid (read) or bvalid (write) for exactly one cycle.
  - Owner rdata = mem_rdata_i for reads. The non-owner's outputs stay 0.
  - Next cycle: IDLE, and last_owner ← owner.
- Timeout:
  - The counter increments each cycle in REQ/WAIT.
  - In the cycle it equals TIMEOUT-1 without completion, force the owner's response pulse with rdata = 0 and bus_err_o = 1, then go to IDLE.
  - A response arriving in that same cycle takes precedence: normal completion, bus_err_o = 0.
- Requesters hold the request until their response. Deasserting early does not abort: the transaction completes and the response still pulses.
- A request still high in the IDLE cycle after a response is a new transaction.
- Minimum transfer latency: grant cycle (IDLE) + REQ cycle with same-cycle ready and resp, giving the response 1 cycle after grant. Back-to-back transfers take ≥ 2 cycles each.
- rdata outputs are 0 whenever the matching valid is low.

Test Plan:
- IFU only: ifu_araddr_i=0x8000_0000, memory ready at once, resp after 2 cycles with 0x0000_0413 → mem_addr_o=0x8000_0000, mem_we_o=0; ifu_rvalid_o pulses 1 cycle with 0x0000_0413; lsu_rvalid_o stays 0.
- LSU write: addr 0x8000_1000, wdata 0xDEADBEEF, wstrb 0xF → mem_we_o=1 with those values held until ready; lsu_bvalid_o pulses once; lsu_rvalid_o=0.
- Simultaneous IFU and LSU read immediately after reset, both held → LSU served first, then IFU; with both held continuously, grants alternate LSU, IFU, LSU.
- mem_ready_i delayed 5 cycles → mem_req_o and fields stable for 6 cycles; no response before acceptance.
- TIMEOUT=8, no mem_resp_i → owner valid pulse on the 8th REQ/WAIT cycle with rdata=0 and bus_err_o=1; next cycle IDLE, and a new request is granted.
- rst asserted in WAIT, then mem_resp_i arrives after reset → no rvalid/bvalid pulse; the next IFU request gets a normal grant.
